// File: rtl/core_ctrl.sv
// core_ctrl: convolution layer sequencer. Walks every output position and
// issues MAC enables with source/parameter addresses, then waits out the
// MAC latency and the output unit before moving on.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   run               layer enable; low aborts to IDLE
//   s_init            start a layer pass (IDLE only)
//   out_busy          output unit draining (checked in WAIT only)
//   id, ks            last channel index, last kernel index
//   ow, oh            last output column / row index
//   is, ip            input row stride, input plane size (words)
//   exec, k_init      MAC enable, accumulator clear
//   ia, wa            source / parameter buffer addresses
//   k_fin, s_fin      position done, layer pass done
//   busy              controller not idle
module core_ctrl #(
    parameter int LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        s_init,
    input  logic        out_busy,
    input  logic [3:0]  id,
    input  logic [9:0]  ks,
    input  logic [9:0]  ow,
    input  logic [9:0]  oh,
    input  logic [9:0]  is,
    input  logic [11:0] ip,
    output logic        exec,
    output logic        k_init,
    output logic [11:0] ia,
    output logic [9:0]  wa,
    output logic        k_fin,
    output logic        s_fin,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, WAIT} state_t;

    localparam logic [3:0] DLAST = 4'(LAT - 1);

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [9:0]  kx_q, kx_d, ky_q, ky_d;
    logic [3:0]  c_q, c_d;
    logic [3:0]  dcnt_q, dcnt_d;
    logic [11:0] pos_q, pos_d;
    logic [11:0] plane_q, plane_d;
    logic [11:0] row_q, row_d;
    logic [11:0] ia_q, ia_d;
    logic [9:0]  wa_q, wa_d;
    logic        exec_q, exec_d;
    logic        kinit_q, kinit_d;
    logic        kfin_q, kfin_d;
    logic        sfin_q, sfin_d;
    logic        busy_q, busy_d;

    logic [11:0] is_w;
    logic [11:0] next_pos;
    logic        x_last;

    assign is_w   = {2'b00, is};
    assign x_last = (x_q == ow);
    // End of a row jumps to the start of the next one: pos + is - ow.
    assign next_pos = x_last ? (pos_q + is_w - {2'b00, ow})
                             : (pos_q + 12'd1);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        kx_d    = kx_q;
        ky_d    = ky_q;
        c_d     = c_q;
        dcnt_d  = dcnt_q;
        pos_d   = pos_q;
        plane_d = plane_q;
        row_d   = row_q;
        ia_d    = ia_q;
        wa_d    = wa_q;
        exec_d  = 1'b0;
        kinit_d = 1'b0;
        sfin_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (s_init) begin
                    state_d = RUN;
                    x_d     = '0;
                    y_d     = '0;
                    kx_d    = '0;
                    ky_d    = '0;
                    c_d     = '0;
                    pos_d   = '0;
                    plane_d = '0;
                    row_d   = '0;
                    ia_d    = '0;
                    wa_d    = '0;
                    exec_d  = 1'b1;
                    kinit_d = 1'b1;
                end
            end
            RUN: begin
                if (kx_q < ks) begin
                    kx_d   = kx_q + 10'd1;
                    ia_d   = ia_q + 12'd1;
                    wa_d   = wa_q + 10'd1;
                    exec_d = 1'b1;
                end else if (ky_q < ks) begin
                    kx_d   = '0;
                    ky_d   = ky_q + 10'd1;
                    row_d  = row_q + is_w;
                    ia_d   = row_q + is_w;
                    wa_d   = wa_q + 10'd1;
                    exec_d = 1'b1;
                end else if (c_q < id) begin
                    kx_d    = '0;
                    ky_d    = '0;
                    c_d     = c_q + 4'd1;
                    plane_d = plane_q + ip;
                    row_d   = plane_q + ip;
                    ia_d    = plane_q + ip;
                    wa_d    = wa_q + 10'd1;
                    exec_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                    dcnt_d  = DLAST;
                end
            end
            DRAIN: begin
                if (dcnt_q == 4'd0) begin
                    state_d = WAIT;
                end else begin
                    dcnt_d = dcnt_q - 4'd1;
                end
            end
            WAIT: begin
                if (!out_busy) begin
                    if (x_last && (y_q == oh)) begin
                        state_d = IDLE;
                        sfin_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        x_d     = x_last ? 10'd0 : x_q + 10'd1;
                        y_d     = x_last ? y_q + 10'd1 : y_q;
                        kx_d    = '0;
                        ky_d    = '0;
                        c_d     = '0;
                        pos_d   = next_pos;
                        plane_d = next_pos;
                        row_d   = next_pos;
                        ia_d    = next_pos;
                        wa_d    = '0;
                        exec_d  = 1'b1;
                        kinit_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // k_fin marks the last DRAIN cycle, LAT cycles after the last MAC.
        kfin_d = (state_d == DRAIN) && (dcnt_d == 4'd0);

        if (!run) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
            kx_d    = '0;
            ky_d    = '0;
            c_d     = '0;
            dcnt_d  = '0;
            pos_d   = '0;
            plane_d = '0;
            row_d   = '0;
            ia_d    = '0;
            wa_d    = '0;
            exec_d  = 1'b0;
            kinit_d = 1'b0;
            kfin_d  = 1'b0;
            sfin_d  = 1'b0;
        end

        // busy covers the s_fin cycle so the pass ends cleanly.
        busy_d = (state_d != IDLE) || sfin_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            kx_q    <= '0;
            ky_q    <= '0;
            c_q     <= '0;
            dcnt_q  <= '0;
            pos_q   <= '0;
            plane_q <= '0;
            row_q   <= '0;
            ia_q    <= '0;
            wa_q    <= '0;
            exec_q  <= 1'b0;
            kinit_q <= 1'b0;
            kfin_q  <= 1'b0;
            sfin_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            kx_q    <= kx_d;
            ky_q    <= ky_d;
            c_q     <= c_d;
            dcnt_q  <= dcnt_d;
            pos_q   <= pos_d;
            plane_q <= plane_d;
            row_q   <= row_d;
            ia_q    <= ia_d;
            wa_q    <= wa_d;
            exec_q  <= exec_d;
            kinit_q <= kinit_d;
            kfin_q  <= kfin_d;
            sfin_q  <= sfin_d;
            busy_q  <= busy_d;
        end
    end

    assign exec   = exec_q;
    assign k_init = kinit_q;
    assign ia     = ia_q;
    assign wa     = wa_q;
    assign k_fin  = kfin_q;
    assign s_fin  = sfin_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: directed and randomized passes of core_ctrl checked against
// a loop-nest reference of the address sequence and pulse timing.
module tb_core_ctrl;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        s_init = 1'b0;
    logic        out_busy = 1'b0;
    logic [3:0]  id = '0;
    logic [9:0]  ks = '0;
    logic [9:0]  ow = '0;
    logic [9:0]  oh = '0;
    logic [9:0]  is = '0;
    logic [11:0] ip = '0;
    logic        exec, k_init, k_fin, s_fin, busy;
    logic [11:0] ia;
    logic [9:0]  wa;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    core_ctrl #(.LAT(LAT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .s_init   (s_init),
        .out_busy (out_busy),
        .id       (id),
        .ks       (ks),
        .ow       (ow),
        .oh       (oh),
        .is       (is),
        .ip       (ip),
        .exec     (exec),
        .k_init   (k_init),
        .ia       (ia),
        .wa       (wa),
        .k_fin    (k_fin),
        .s_fin    (s_fin),
        .busy     (busy)
    );

    typedef struct {
        logic [11:0] ia;
        logic [9:0]  wa;
        bit          first;
        bit          last;
    } mac_t;

    mac_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int k, input int c, input int w,
                           input int h, input int s, input int p);
        ks = 10'(k);
        id = 4'(c);
        ow = 10'(w);
        oh = 10'(h);
        is = 10'(s);
        ip = 12'(p);
    endtask

    // Expected MAC stream: every position, every channel/kernel tap,
    // address = y*is + x + c*ip + ky*is + kx (mod 4096).
    task automatic build_model(output int npos);
        int   n;
        int   e;
        mac_t m;
        exp_q.delete();
        npos = 0;
        e = (int'(id) + 1) * (int'(ks) + 1) * (int'(ks) + 1);
        for (int y = 0; y <= int'(oh); y++) begin
            for (int x = 0; x <= int'(ow); x++) begin
                n = 0;
                npos++;
                for (int c = 0; c <= int'(id); c++) begin
                    for (int ky = 0; ky <= int'(ks); ky++) begin
                        for (int kx = 0; kx <= int'(ks); kx++) begin
                            m.ia = 12'(y * int'(is) + x + c * int'(ip)
                                       + ky * int'(is) + kx);
                            m.wa = 10'(n);
                            m.first = (n == 0);
                            m.last = (n == e - 1);
                            exp_q.push_back(m);
                            n++;
                        end
                    end
                end
            end
        end
    endtask

    // One full pass. hfirst >= 0 fixes the out_busy hold after the
    // first k_fin; noise toggles s_init/out_busy where they are ignored.
    task automatic do_pass(input int hfirst, input bit noise);
        int   npos, cyc, nkfin, left, h;
        int   exp_kfin, next_kinit, sfin_exp;
        bit   done, waiting;
        mac_t m;
        build_model(npos);
        nkfin = 0;
        left = 0;
        h = 0;
        exp_kfin = -1;
        next_kinit = 1;
        sfin_exp = -1;
        done = 1'b0;
        waiting = 1'b0;
        cyc = 0;
        @(negedge clk);
        s_init = 1'b1;
        out_busy = 1'b0;
        for (int t = 0; t < 4000 && !done; t++) begin
            @(negedge clk);
            cyc++;
            chk1("busy", busy, 1'b1);
            if (exec) begin
                waiting = 1'b0;
                if (exp_q.size() == 0) begin
                    chk1("exec_extra", exec, 1'b0);
                end else begin
                    m = exp_q.pop_front();
                    chk("ia", 32'(ia), 32'(m.ia));
                    chk("wa", 32'(wa), 32'(m.wa));
                    chk1("k_init", k_init, m.first);
                    if (m.first) chk("kinit_cycle", cyc, next_kinit);
                    if (m.last) exp_kfin = cyc + LAT;
                end
            end else begin
                chk1("kinit_noexec", k_init, 1'b0);
            end
            chk1("k_fin", k_fin, cyc == exp_kfin);
            chk1("s_fin", s_fin, cyc == sfin_exp);
            if (k_fin) begin
                nkfin++;
                exp_kfin = -1;
                waiting = 1'b1;
                h = (nkfin == 1 && hfirst >= 0) ? hfirst
                                                : $urandom_range(3, 0);
                left = h;
                if (nkfin >= npos) sfin_exp = cyc + h + 2;
                else next_kinit = cyc + h + 2;
            end
            if (s_fin) begin
                chk("sfin_queue", exp_q.size(), 0);
                chk("kfin_count", nkfin, npos);
                done = 1'b1;
            end
            s_init = 1'b0;
            if (noise && !done) s_init = ($urandom_range(3, 0) == 0);
            if (done) begin
                out_busy = 1'b0;
            end else if (k_fin) begin
                out_busy = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            end else if (left > 0) begin
                out_busy = 1'b1;
                left--;
            end else if (waiting) begin
                out_busy = 1'b0;
            end else begin
                out_busy = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            end
        end
        if (!done) chk1("timeout", done, 1'b1);
        s_init = 1'b0;
        out_busy = 1'b0;
        @(negedge clk);
        chk1("busy_end", busy, 1'b0);
        chk1("exec_end", exec, 1'b0);
        chk1("s_fin_end", s_fin, 1'b0);
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, "_exec"}, exec, 1'b0);
        chk1({tag, "_kinit"}, k_init, 1'b0);
        chk1({tag, "_kfin"}, k_fin, 1'b0);
        chk1({tag, "_sfin"}, s_fin, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_ia"}, 32'(ia), 32'd0);
        chk({tag, "_wa"}, 32'(wa), 32'd0);
    endtask

    initial begin
        int k, c, w, h, s;

        set_cfg(0, 0, 0, 0, 4, 16);
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        rst_n = 1'b1;
        run = 1'b1;
        @(negedge clk);

        // single-tap single-position pass, exact pulse timing
        set_cfg(0, 0, 0, 0, 4, 16);
        do_pass(0, 1'b0);

        // 3x3 kernel, two positions
        set_cfg(2, 0, 1, 0, 4, 0);
        do_pass(-1, 1'b0);

        // two channels, 2x2 positions
        set_cfg(0, 1, 1, 1, 4, 16);
        do_pass(-1, 1'b0);

        // long out_busy hold after the first k_fin
        do_pass(5, 1'b0);

        // ignored s_init / out_busy activity
        do_pass(-1, 1'b1);

        // run drop mid-RUN
        set_cfg(1, 1, 1, 1, 5, 30);
        @(negedge clk);
        s_init = 1'b1;
        @(negedge clk);
        s_init = 1'b0;
        repeat ($urandom_range(4, 1)) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        chk_quiet("abort");
        run = 1'b1;
        repeat (LAT + 3) begin
            @(negedge clk);
            chk1("abort_kfin", k_fin, 1'b0);
            chk1("abort_sfin", s_fin, 1'b0);
        end
        do_pass(-1, 1'b0);

        // run drop on the cycle k_fin would be registered
        set_cfg(0, 0, 0, 0, 4, 16);
        @(negedge clk);
        s_init = 1'b1;
        @(negedge clk);
        s_init = 1'b0;
        chk1("sup_exec", exec, 1'b1);
        repeat (LAT - 1) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        chk_quiet("sup");
        run = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk1("sup_kfin_late", k_fin, 1'b0);
            chk1("sup_sfin_late", s_fin, 1'b0);
        end

        // async reset in DRAIN
        @(negedge clk);
        s_init = 1'b1;
        @(negedge clk);
        s_init = 1'b0;
        @(negedge clk);
        chk1("drain_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_quiet("rst_drain");
        repeat (LAT + 2) begin
            @(negedge clk);
            chk1("rst_kfin", k_fin, 1'b0);
            chk1("rst_sfin", s_fin, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        set_cfg(0, 1, 1, 1, 4, 16);
        do_pass(-1, 1'b0);

        // randomized geometries, address wrap via large ip
        repeat (6) begin
            k = $urandom_range(2, 0);
            c = $urandom_range(2, 0);
            w = $urandom_range(2, 0);
            h = $urandom_range(2, 0);
            s = $urandom_range(20, w + k + 1);
            set_cfg(k, c, w, h, s, $urandom_range(4095, 0));
            do_pass(-1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
